pipe_stage_reg: RTL and testbench

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_stage_reg_pkg.sv | 29 ++
 rtl/pipe_stage_reg.sv | 111 +++++++++++
 tb/tb_pipe_stage_reg.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_reg_pkg.sv
// Shared pipeline definitions: stage-register state encoding, default bus widths,
// and the bit layout of the ID/EX payload.
package pipe_stage_reg_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } stage_state_t;

    localparam int CTRL_W_DEF = 6;
    localparam int DATA_W_DEF = 156;

    // ID/EX payload, LSB first: signed_imm, shift_operand, src2, src1, dest, exe_cmd, valRm, valRn, pc
    localparam int IDEX_IMM_LSB   = 0;
    localparam int IDEX_IMM_W     = 32;
    localparam int IDEX_SHOP_LSB  = 32;
    localparam int IDEX_SHOP_W    = 12;
    localparam int IDEX_SRC2_LSB  = 44;
    localparam int IDEX_SRC1_LSB  = 48;
    localparam int IDEX_DEST_LSB  = 52;
    localparam int IDEX_CMD_LSB   = 56;
    localparam int IDEX_REG_W     = 4;
    localparam int IDEX_VALRM_LSB = 60;
    localparam int IDEX_VALRN_LSB = 92;
    localparam int IDEX_PC_LSB    = 124;
    localparam int IDEX_WORD_W    = 32;

endpackage

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register (2-entry skid or 1-entry), one-cycle latency, in order.
// Backpressure: skid mode stalls upstream only when full (no out_ready->in_ready path); 1-entry mode passes out_ready through.
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int CTRL_W  = CTRL_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter bit SKID_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    stage_state_t      state_q, state_d;
    logic [CTRL_W-1:0] head_ctrl_q, head_ctrl_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0] head_data_q, head_data_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic              in_fire, out_fire;

    always_comb begin
        if (SKID_EN) in_ready = (state_q != ST_TWO);
        else         in_ready = (state_q == ST_EMPTY) | out_ready;
    end

    assign out_valid = (state_q != ST_EMPTY);
    assign out_ctrl  = out_valid ? head_ctrl_q : '0;
    assign out_data  = head_data_q;
    assign occupancy = state_q;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    always_comb begin
        state_d     = state_q;
        head_ctrl_d = head_ctrl_q;
        head_data_d = head_data_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;
        if (flush) begin
            state_d     = ST_EMPTY;
            head_ctrl_d = '0;
            skid_ctrl_d = '0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_d     = ST_ONE;
                        head_ctrl_d = in_ctrl;
                        head_data_d = in_data;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        head_ctrl_d = in_ctrl;
                        head_data_d = in_data;
                    end else if (in_fire && SKID_EN) begin
                        state_d     = ST_TWO;
                        skid_ctrl_d = in_ctrl;
                        skid_data_d = in_data;
                    end else if (out_fire) begin
                        state_d     = ST_EMPTY;
                        head_ctrl_d = '0;
                    end
                end
                ST_TWO: begin
                    // in_ready is low here, so only a pop can happen
                    if (out_fire) begin
                        state_d     = ST_ONE;
                        head_ctrl_d = skid_ctrl_q;
                        head_data_d = skid_data_q;
                        skid_ctrl_d = '0;
                    end
                end
                default: begin
                    state_d     = ST_EMPTY;
                    head_ctrl_d = '0;
                    skid_ctrl_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            head_ctrl_q <= '0;
            skid_ctrl_q <= '0;
        end else begin
            state_q     <= state_d;
            head_ctrl_q <= head_ctrl_d;
            skid_ctrl_q <= skid_ctrl_d;
        end
    end

    // Payload is only meaningful alongside a valid state, so it carries no reset
    always_ff @(posedge clk) begin
        head_data_q <= head_data_d;
        skid_data_q <= skid_data_d;
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench: skid-mode vector table plus reset and 1-entry-mode sequences.
module tb_pipe_stage_reg;

    localparam int CW = 6;
    localparam int DW = 156;

    logic          clk;
    logic          rst_n;
    logic          flush, in_valid, out_ready;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;
    logic          in_ready, out_valid;
    logic [CW-1:0] out_ctrl;
    logic [DW-1:0] out_data;
    logic [1:0]    occupancy;

    logic          n_flush, n_in_valid, n_out_ready;
    logic [CW-1:0] n_in_ctrl;
    logic [DW-1:0] n_in_data;
    logic          n_in_ready, n_out_valid;
    logic [CW-1:0] n_out_ctrl;
    logic [DW-1:0] n_out_data;
    logic [1:0]    n_occupancy;

    int checks = 0;
    int errors = 0;

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID_EN(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
        .occupancy(occupancy)
    );

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID_EN(1'b0)) u_noskid (
        .clk(clk), .rst_n(rst_n), .flush(n_flush),
        .in_valid(n_in_valid), .in_ready(n_in_ready), .in_ctrl(n_in_ctrl), .in_data(n_in_data),
        .out_valid(n_out_valid), .out_ready(n_out_ready), .out_ctrl(n_out_ctrl), .out_data(n_out_data),
        .occupancy(n_occupancy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic          fl;
        logic          iv;
        logic [CW-1:0] ic;
        logic [DW-1:0] id;
        logic          ordy;
        logic          e_ir;
        logic          e_ov;
        logic [CW-1:0] e_oc;
        logic [DW-1:0] e_od;
        logic [1:0]    e_occ;
    } vec_t;

    vec_t tv[$];

    task automatic add(input logic fl, input logic iv, input logic [CW-1:0] ic, input int id,
                       input logic ordy, input logic e_ir, input logic e_ov,
                       input logic [CW-1:0] e_oc, input int e_od, input logic [1:0] e_occ);
        vec_t v;
        v.fl = fl; v.iv = iv; v.ic = ic; v.id = DW'(id); v.ordy = ordy;
        v.e_ir = e_ir; v.e_ov = e_ov; v.e_oc = e_oc; v.e_od = DW'(e_od); v.e_occ = e_occ;
        tv.push_back(v);
    endtask

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_ctrl = '0; in_data = '0;
        n_flush = 1'b0; n_in_valid = 1'b0; n_out_ready = 1'b0; n_in_ctrl = '0; n_in_data = '0;

        // streaming 1..8
        for (int i = 1; i <= 8; i++)
            add(0, 1, CW'(i), i, 1, 1, 1, CW'(i), i, 2'd1);
        add(0, 0, 6'h00, 0, 1, 1, 0, 6'h00, 0, 2'd0);
        // stall A B C, then drain
        add(0, 1, 6'h11, 'hA, 0, 1, 1, 6'h11, 'hA, 2'd1);
        add(0, 1, 6'h22, 'hB, 0, 0, 1, 6'h11, 'hA, 2'd2);
        add(0, 1, 6'h33, 'hC, 0, 0, 1, 6'h11, 'hA, 2'd2);
        add(0, 1, 6'h33, 'hC, 1, 1, 1, 6'h22, 'hB, 2'd1);
        add(0, 1, 6'h33, 'hC, 1, 1, 1, 6'h33, 'hC, 2'd1);
        add(0, 0, 6'h00, 0,   1, 1, 0, 6'h00, 0,   2'd0);
        // simultaneous push/pop in ONE
        add(0, 1, 6'h01, 1,    0, 1, 1, 6'h01, 1,    2'd1);
        add(0, 1, 6'b101010, 'h2A, 1, 1, 1, 6'b101010, 'h2A, 2'd1);
        add(0, 0, 6'h00, 0,    1, 1, 0, 6'h00, 0,    2'd0);
        // flush while full with a concurrent push
        add(0, 1, 6'h3F, 'h55, 0, 1, 1, 6'h3F, 'h55, 2'd1);
        add(0, 1, 6'h07, 'h66, 0, 0, 1, 6'h3F, 'h55, 2'd2);
        add(1, 1, 6'h15, 'h77, 1, 1, 0, 6'h00, 0,    2'd0);
        add(0, 0, 6'h00, 0,    1, 1, 0, 6'h00, 0,    2'd0);
        add(0, 1, 6'h09, 'h88, 0, 1, 1, 6'h09, 'h88, 2'd1);
        add(0, 0, 6'h00, 0,    1, 1, 0, 6'h00, 0,    2'd0);

        #12;
        chk("rst_out_valid", DW'(out_valid), DW'(1'b0));
        chk("rst_occupancy", DW'(occupancy), DW'(2'd0));
        chk("rst_out_ctrl",  DW'(out_ctrl),  DW'(6'h00));
        chk("rst_in_ready",  DW'(in_ready),  DW'(1'b1));
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tv[k]) begin
            @(negedge clk);
            flush = tv[k].fl; in_valid = tv[k].iv; in_ctrl = tv[k].ic;
            in_data = tv[k].id; out_ready = tv[k].ordy;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_in_ready", k),  DW'(in_ready),  DW'(tv[k].e_ir));
            chk($sformatf("v%0d_out_valid", k), DW'(out_valid), DW'(tv[k].e_ov));
            chk($sformatf("v%0d_out_ctrl", k),  DW'(out_ctrl),  DW'(tv[k].e_oc));
            chk($sformatf("v%0d_occupancy", k), DW'(occupancy), DW'(tv[k].e_occ));
            if (tv[k].e_ov)
                chk($sformatf("v%0d_out_data", k), out_data, tv[k].e_od);
        end

        // asynchronous reset while holding two entries
        @(negedge clk);
        flush = 1'b0; out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 6'h2D; in_data = DW'('h1);
        @(negedge clk);
        in_ctrl = 6'h1B; in_data = DW'('h2);
        @(negedge clk);
        in_valid = 1'b0;
        chk("pre_rst_occupancy", DW'(occupancy), DW'(2'd2));
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", DW'(out_valid), DW'(1'b0));
        chk("async_rst_out_ctrl",  DW'(out_ctrl),  DW'(6'h00));
        chk("async_rst_occupancy", DW'(occupancy), DW'(2'd0));
        chk("async_rst_in_ready",  DW'(in_ready),  DW'(1'b1));
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_empty", DW'(out_valid), DW'(1'b0));

        // single-entry mode
        @(negedge clk);
        n_in_valid = 1'b1; n_in_ctrl = 6'h05; n_in_data = DW'('h5); n_out_ready = 1'b0;
        @(posedge clk);
        #1;
        chk("ns_occ_one",     DW'(n_occupancy), DW'(2'd1));
        chk("ns_ready_low",   DW'(n_in_ready),  DW'(1'b0));
        n_out_ready = 1'b1;
        #1;
        chk("ns_ready_follow", DW'(n_in_ready), DW'(1'b1));
        n_out_ready = 1'b0;
        #1;
        chk("ns_ready_drop",   DW'(n_in_ready), DW'(1'b0));
        @(negedge clk);
        n_in_ctrl = 6'h06; n_in_data = DW'('h6);
        @(posedge clk);
        #1;
        chk("ns_stall_occ",  DW'(n_occupancy), DW'(2'd1));
        chk("ns_stall_data", n_out_data, DW'('h5));
        chk("ns_stall_ctrl", DW'(n_out_ctrl), DW'(6'h05));
        @(negedge clk);
        n_out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("ns_swap_occ",  DW'(n_occupancy), DW'(2'd1));
        chk("ns_swap_data", n_out_data, DW'('h6));
        @(negedge clk);
        n_in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("ns_drain_valid", DW'(n_out_valid), DW'(1'b0));
        chk("ns_drain_ctrl",  DW'(n_out_ctrl),  DW'(6'h00));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
